// File: rtl/bf_pkg.sv
// Shared definitions for the Bellman-Ford iteration sequencer.
// Holds the sequencer state encoding, the default graph geometry and
// datapath latency, and a constant-folding clog2 helper used to size
// address, pass and drain counters.
package bf_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int N_DEF      = 8;
    localparam int AW_DEF     = clog2(N_DEF);
    localparam int ITER_W_DEF = clog2(N_DEF);
    localparam int LAT_DEF    = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWEEP  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/bf_edge_counter.sv
// Nested source/destination counter walking the adjacency matrix in
// row-major order, self-edges included.
// Ports:
//   clk, rst_global  clock and synchronous active-low reset
//   clear            return both addresses to (0,0)
//   advance          step to the next edge; (N-1,N-1) wraps to (0,0)
//   src_addr         source node of the current edge
//   dst_addr         destination node of the current edge
//   last             current edge is (N-1,N-1)
module bf_edge_counter
    import bf_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_global,
    input  logic          clear,
    input  logic          advance,
    output logic [AW-1:0] src_addr,
    output logic [AW-1:0] dst_addr,
    output logic          last
);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    assign last = (src_addr == LAST_IDX) && (dst_addr == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_global || clear) begin
            src_addr <= '0;
            dst_addr <= '0;
        end else if (advance) begin
            if (dst_addr == LAST_IDX) begin
                dst_addr <= '0;
                src_addr <= (src_addr == LAST_IDX) ? '0 : src_addr + 1'b1;
            end else begin
                dst_addr <= dst_addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bf_iteration_sequencer.sv
// Pass sequencer for the 8x8 Bellman-Ford relaxation datapath. Each pass
// issues every (src,dst) edge once, waits out the datapath latency, then
// decides between another pass, convergence, or a negative cycle.
// Ports:
//   clk, rst_global  clock and synchronous active-low reset
//   start            begin a run (honoured only in IDLE or DONE)
//   stall            datapath back-pressure, holds the edge walk
//   relax_valid      relaxed is valid this cycle
//   relaxed          the returned edge improved a distance
//   src_addr         source node of the current edge
//   dst_addr         destination node of the current edge
//   edge_valid       current edge issued this cycle
//   iteration_done   one-cycle pulse at the end of each pass
//   finish           run complete, held until the next start
//   converged        last pass produced no update
//   neg_cycle        pass N-1 still produced an update
//   iter_count       index of the current pass
//
// state  | meaning
// IDLE   | waiting for start after reset
// SWEEP  | issuing edges, one per unstalled cycle
// DRAIN  | waiting LAT cycles for the last results to return
// DECIDE | end of pass: loop, converge or flag negative cycle
// DONE   | run finished, flags held, waiting for start
module bf_iteration_sequencer
    import bf_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int AW     = AW_DEF,
    parameter int ITER_W = ITER_W_DEF,
    parameter int LAT    = LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_global,
    input  logic              start,
    input  logic              stall,
    input  logic              relax_valid,
    input  logic              relaxed,
    output logic [AW-1:0]     src_addr,
    output logic [AW-1:0]     dst_addr,
    output logic              edge_valid,
    output logic              iteration_done,
    output logic              finish,
    output logic              converged,
    output logic              neg_cycle,
    output logic [ITER_W-1:0] iter_count
);
    // Drain down-counter must hold LAT-1; keep at least one bit for LAT = 1.
    localparam int DW = (clog2(LAT) > 0) ? clog2(LAT) : 1;

    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic          any_update;
    logic          run_start;
    logic          advance;
    logic          last;

    assign run_start      = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign advance        = (state == ST_SWEEP) && !stall;
    assign edge_valid     = advance;
    assign iteration_done = (state == ST_DECIDE);
    assign finish         = (state == ST_DONE);

    bf_edge_counter #(
        .N  (N),
        .AW (AW)
    ) u_edge_counter (
        .clk        (clk),
        .rst_global (rst_global),
        .clear      (run_start),
        .advance    (advance),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .last       (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_global) begin
            state      <= ST_IDLE;
            drain_cnt  <= '0;
            any_update <= 1'b0;
            converged  <= 1'b0;
            neg_cycle  <= 1'b0;
            iter_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        iter_count <= '0;
                        any_update <= 1'b0;
                        converged  <= 1'b0;
                        neg_cycle  <= 1'b0;
                        state      <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (relax_valid && relaxed) begin
                        any_update <= 1'b1;
                    end
                    if (advance && last) begin
                        drain_cnt <= DW'(LAT - 1);
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The result of edge (N-1,N-1) lands in the final drain cycle.
                    if (relax_valid && relaxed) begin
                        any_update <= 1'b1;
                    end
                    if (drain_cnt == '0) begin
                        state <= ST_DECIDE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_DECIDE: begin
                    if (!any_update) begin
                        converged <= 1'b1;
                        state     <= ST_DONE;
                    end else if (iter_count == ITER_W'(N - 1)) begin
                        neg_cycle <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        iter_count <= iter_count + 1'b1;
                        any_update <= 1'b0;
                        state      <= ST_SWEEP;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_iteration_sequencer.sv
// Self-checking bench for bf_iteration_sequencer. A behavioural datapath
// returns results LAT cycles after each issued edge; an edge improves a
// distance while the pass index is below its entry in kmat. The run
// outcome follows from the largest kmat entry alone.
module tb_bf_iteration_sequencer;
    localparam int N      = 8;
    localparam int AW     = 3;
    localparam int ITER_W = 3;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              rst_global = 1'b0;
    logic              start = 1'b0;
    logic              stall = 1'b0;
    logic              relax_valid = 1'b0;
    logic              relaxed = 1'b0;
    logic [AW-1:0]     src_addr;
    logic [AW-1:0]     dst_addr;
    logic              edge_valid;
    logic              iteration_done;
    logic              finish;
    logic              converged;
    logic              neg_cycle;
    logic [ITER_W-1:0] iter_count;

    always #5 clk = ~clk;

    bf_iteration_sequencer #(
        .N      (N),
        .AW     (AW),
        .ITER_W (ITER_W),
        .LAT    (LAT)
    ) dut (
        .clk            (clk),
        .rst_global     (rst_global),
        .start          (start),
        .stall          (stall),
        .relax_valid    (relax_valid),
        .relaxed        (relaxed),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .edge_valid     (edge_valid),
        .iteration_done (iteration_done),
        .finish         (finish),
        .converged      (converged),
        .neg_cycle      (neg_cycle),
        .iter_count     (iter_count)
    );

    int   checks = 0;
    int   errors = 0;
    int   kmat [N][N];
    logic dly_v [LAT];
    logic dly_r [LAT];

    typedef struct {
        int   us;
        int   ud;
        int   up;
        int   smode;
        int   busy_c;
        int   exp_done;
        logic exp_conv;
        logic exp_neg;
        int   exp_iter;
        int   exp_len0;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_kmat();
        for (int s = 0; s < N; s++)
            for (int d = 0; d < N; d++)
                kmat[s][d] = 0;
    endtask

    // smode: 0 no stall, 1 five-cycle stall at edge (3,5) of pass 0, 2 random.
    task automatic do_run(input string tag, input int smode, input int busy_c,
                          output int n_done, output int len0,
                          output logic conv, output logic neg, output int itc);
        int   pass, pass_start, edges_this, stall_cnt, stalled5;
        int   bad_order, bad_len, bad_cnt, bad_iter, bad_hold, bad_pulse, bad_fin;
        logic prev_done, r;
        bit   done_flag;
        pass = 0; pass_start = 1; edges_this = 0; stall_cnt = 0; stalled5 = 0;
        bad_order = 0; bad_len = 0; bad_cnt = 0; bad_iter = 0;
        bad_hold = 0; bad_pulse = 0; bad_fin = 0;
        prev_done = 1'b0; done_flag = 1'b0;
        n_done = 0; len0 = -1; conv = 1'b0; neg = 1'b0; itc = -1;
        for (int i = 0; i < LAT; i++) begin
            dly_v[i] = 1'b0;
            dly_r[i] = 1'b0;
        end
        for (int c = 0; c < 4000 && !done_flag; c++) begin
            @(posedge clk); #1;
            start       = (c == 0) || (c == busy_c);
            relax_valid = dly_v[LAT-1];
            relaxed     = dly_r[LAT-1];
            case (smode)
                1: stall = (c > 0) && (pass == 0) && (src_addr == 3) && (dst_addr == 5) && (stalled5 < 5);
                2: stall = ($urandom_range(0, 3) == 0);
                default: stall = 1'b0;
            endcase
            if (smode == 1 && stall) stalled5++;
            @(negedge clk);
            if (c > 0) begin
                if (stall && edges_this < N*N) stall_cnt++;
                if (smode == 1 && stall && (src_addr != 3 || dst_addr != 5 || edge_valid)) bad_hold++;
                if (edge_valid) begin
                    if (src_addr != AW'(edges_this / N) || dst_addr != AW'(edges_this % N)) bad_order++;
                    edges_this++;
                end
                if (iteration_done) begin
                    if (prev_done) bad_pulse++;
                    if (edges_this != N*N) bad_cnt++;
                    if (iter_count != ITER_W'(pass)) bad_iter++;
                    if (c - pass_start + 1 != N*N + stall_cnt + LAT + 1) bad_len++;
                    if (pass == 0) len0 = c;
                    pass++;
                    n_done++;
                    pass_start = c + 1;
                    edges_this = 0;
                    stall_cnt  = 0;
                end
                if (finish) begin
                    if (!prev_done) bad_fin++;
                    conv = converged;
                    neg  = neg_cycle;
                    itc  = int'(iter_count);
                    done_flag = 1'b1;
                end
                prev_done = iteration_done;
            end
            r = edge_valid ? (pass < kmat[src_addr][dst_addr]) : 1'($urandom_range(0, 1));
            for (int i = LAT - 1; i > 0; i--) begin
                dly_v[i] = dly_v[i-1];
                dly_r[i] = dly_r[i-1];
            end
            dly_v[0] = edge_valid;
            dly_r[0] = r;
        end
        start = 1'b0; stall = 1'b0; relax_valid = 1'b0; relaxed = 1'b0;
        check({tag, "_finished"}, done_flag, 1);
        check({tag, "_edge_order"}, bad_order, 0);
        check({tag, "_edges_per_pass"}, bad_cnt, 0);
        check({tag, "_iter_at_done"}, bad_iter, 0);
        check({tag, "_pass_len"}, bad_len, 0);
        check({tag, "_done_pulse"}, bad_pulse, 0);
        check({tag, "_finish_after_decide"}, bad_fin, 0);
        check({tag, "_flags_exclusive"}, conv && neg, 0);
        if (smode == 1) check({tag, "_stall_hold"}, bad_hold, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_done, len0, itc, kmax, e_done;
        logic conv, neg;

        tbl[0] = '{us:0, ud:0, up:0,   smode:0, busy_c:-1, exp_done:1, exp_conv:1, exp_neg:0, exp_iter:0, exp_len0:67};
        tbl[1] = '{us:2, ud:5, up:3,   smode:0, busy_c:-1, exp_done:4, exp_conv:1, exp_neg:0, exp_iter:3, exp_len0:67};
        tbl[2] = '{us:0, ud:1, up:100, smode:0, busy_c:-1, exp_done:8, exp_conv:0, exp_neg:1, exp_iter:7, exp_len0:67};
        tbl[3] = '{us:0, ud:0, up:0,   smode:1, busy_c:-1, exp_done:1, exp_conv:1, exp_neg:0, exp_iter:0, exp_len0:72};
        tbl[4] = '{us:7, ud:7, up:1,   smode:0, busy_c:-1, exp_done:2, exp_conv:1, exp_neg:0, exp_iter:1, exp_len0:67};
        tbl[5] = '{us:0, ud:0, up:7,   smode:0, busy_c:20, exp_done:8, exp_conv:1, exp_neg:0, exp_iter:7, exp_len0:67};
        tbl[6] = '{us:4, ud:2, up:8,   smode:0, busy_c:-1, exp_done:8, exp_conv:0, exp_neg:1, exp_iter:7, exp_len0:67};

        // Reset held with start asserted.
        rst_global = 1'b0; start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_edge_valid", edge_valid, 0);
        check("rst_iteration_done", iteration_done, 0);
        check("rst_finish", finish, 0);
        check("rst_converged", converged, 0);
        check("rst_neg_cycle", neg_cycle, 0);
        check("rst_iter_count", iter_count, 0);
        check("rst_src", src_addr, 0);
        check("rst_dst", dst_addr, 0);
        @(posedge clk); #1;
        rst_global = 1'b1; start = 1'b0;
        @(negedge clk);
        check("post_rst_edge_valid_0", edge_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_edge_valid_1", edge_valid, 0);

        for (int t = 0; t < 7; t++) begin
            clear_kmat();
            kmat[tbl[t].us][tbl[t].ud] = tbl[t].up;
            do_run($sformatf("vec%0d", t), tbl[t].smode, tbl[t].busy_c, n_done, len0, conv, neg, itc);
            check($sformatf("vec%0d_passes", t), n_done, tbl[t].exp_done);
            check($sformatf("vec%0d_converged", t), conv, tbl[t].exp_conv);
            check($sformatf("vec%0d_neg_cycle", t), neg, tbl[t].exp_neg);
            check($sformatf("vec%0d_iter_count", t), itc, tbl[t].exp_iter);
            check($sformatf("vec%0d_first_done_cycle", t), len0, tbl[t].exp_len0);
        end

        // finish and flags stay up while idle in DONE.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("done_hold_finish", finish, 1);
        check("done_hold_neg_cycle", neg_cycle, 1);

        // Randomized runs: sparse update matrix, random stalls and busy starts.
        for (int t = 0; t < 6; t++) begin
            clear_kmat();
            kmax = 0;
            for (int s = 0; s < N; s++)
                for (int d = 0; d < N; d++)
                    if ($urandom_range(0, 15) == 0) begin
                        kmat[s][d] = $urandom_range(1, 10);
                        if (kmat[s][d] > kmax) kmax = kmat[s][d];
                    end
            e_done = (kmax >= N) ? N : kmax + 1;
            do_run($sformatf("rnd%0d", t), 2, $urandom_range(1, 60), n_done, len0, conv, neg, itc);
            check($sformatf("rnd%0d_passes", t), n_done, e_done);
            check($sformatf("rnd%0d_converged", t), conv, kmax < N);
            check($sformatf("rnd%0d_neg_cycle", t), neg, kmax >= N);
            check($sformatf("rnd%0d_iter_count", t), itc, e_done - 1);
        end

        // Reset in the middle of a sweep, then a clean restart.
        clear_kmat();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 200 && !(src_addr == 2 && dst_addr == 4); i++) begin
            @(posedge clk); #1;
        end
        check("mid_reached_src", src_addr, 2);
        check("mid_reached_dst", dst_addr, 4);
        rst_global = 1'b0;
        @(posedge clk); #1;
        rst_global = 1'b1;
        @(negedge clk);
        check("mid_rst_edge_valid", edge_valid, 0);
        check("mid_rst_src", src_addr, 0);
        check("mid_rst_dst", dst_addr, 0);
        check("mid_rst_finish", finish, 0);
        check("mid_rst_iter_count", iter_count, 0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("restart_edge_valid", edge_valid, 1);
        check("restart_src", src_addr, 0);
        check("restart_dst", dst_addr, 0);
        check("restart_iter_count", iter_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bf_iteration_sequencer.md
# bf_iteration_sequencer

Sequences the relaxation datapath of the 8x8 Bellman-Ford engine. On `start` it sweeps every (src, dst) edge pair of the adjacency matrix once per pass and collects the datapath's "distance improved" flags. After each pass it decides whether to run another pass, declare convergence, or flag a negative cycle after the N-th pass. It sits between the top-level controller and the address/relax datapath, and produces the `iteration_done` and `finish` strobes the controller consumes.

## Interface
- `N`, 8: number of graph nodes; the edge sweep covers N*N pairs.
- `AW`, 3: node address width; equals clog2(N).
- `ITER_W`, 3: pass counter width; holds 0..N-1.
- `LAT`, 2: fixed datapath latency in cycles, from `edge_valid` to the matching `relax_valid`; LAT >= 1.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_global`  in  1  reset, synchronous and active-low; 0 = reset.
- `start`  in  1  begins a new run; sampled only in IDLE or DONE.
- `stall`  in  1  datapath back-pressure; while 1, no edge is issued.
- `relax_valid`  in  1  `relaxed` carries a valid result this cycle.
- `relaxed`  in  1  the edge result improved a distance.
- `src_addr`  out  AW  source node of the current edge.
- `dst_addr`  out  AW  destination node of the current edge.
- `edge_valid`  out  1  the (src_addr, dst_addr) pair is issued this cycle.
- `iteration_done`  out  1  one-cycle pulse at the end of each pass.
- `finish`  out  1  run complete; held until the next `start` or reset.
- `converged`  out  1  a pass produced no update; valid while `finish` = 1.
- `neg_cycle`  out  1  the N-th pass still produced an update; valid while `finish` = 1.
- `iter_count`  out  ITER_W  index of the current pass, starting at 0.

## Operation
- States: IDLE, SWEEP, DRAIN, DECIDE, DONE.
- **Reset:**
  - Forces IDLE.
  - All outputs reset to 0.
  - Internal `any_update`, the drain counter and both address counters reset to 0.
- **IDLE and DONE, `start` = 1:**
  - Clear `iter_count`, `any_update`, `src_addr`, `dst_addr`, `converged`, `neg_cycle` and `finish`.
  - Go to SWEEP.
- **SWEEP:**
  - `edge_valid` = !`stall`.
  - On each issued edge, `dst_addr` increments.
  - When `dst_addr` = N-1, it wraps to 0 and `src_addr` increments.
  - When the edge (N-1, N-1) is issued, both addresses wrap to 0 and the state goes to DRAIN.
  - While `stall` = 1, the addresses hold.
  - Edges are issued in row-major order; self-edges are included.
- **DRAIN:**
  - Lasts exactly LAT cycles, counted by the drain counter.
  - Then go to DECIDE.
  - `stall` is ignored.
- **Collecting updates:**
  - In SWEEP and DRAIN, `any_update` is set to 1 when `relax_valid` and `relaxed` are both 1.
  - In other states, `relax_valid` is ignored.
  - `relax_valid` in DECIDE is a protocol error and is dropped.
- **DECIDE** (one cycle):
  - `iteration_done` = 1.
  - If `any_update` = 0: set `converged` = 1 and `finish` = 1, go to DONE.
  - Else if `iter_count` = N-1: set `neg_cycle` = 1 and `finish` = 1, go to DONE.
  - Else: increment `iter_count`, clear `any_update`, go to SWEEP.
- **`start` outside IDLE/DONE:** ignored.
- **Reset mid-run:** overrides everything and returns to IDLE the following cycle.

## Timing
- `edge_valid`, `iteration_done` and `finish` are Moore-style, decoded from the state register.
- `iteration_done` is never high for two consecutive cycles.
- Pass length with no stall: N*N + LAT + 1 cycles.
  - With N = 8 and LAT = 2, that is 67 cycles.
  - Each stalled SWEEP cycle adds one cycle.
- The first edge (0,0) is issued in the cycle after `start` is sampled.
- `finish` rises in the cycle after DECIDE, together with `converged`/`neg_cycle`.
- `converged` and `neg_cycle` are never both 1.
- `iter_count` changes only on a DECIDE-to-SWEEP transition or on a run restart.
  - It does not wrap: the pass at `iter_count` = N-1 always ends the run.

## Structure
- Shared package `bf_pkg` holds:
  - the state encoding constants;
  - the default N, AW, LAT;
  - the clog2 helper.
- One sub-module, `bf_edge_counter`: the nested src/dst counter.
  - Inputs: clear, advance.
  - Outputs: src_addr, dst_addr, last (high when src = dst = N-1).
- The FSM, drain counter and update flag live in the top module.

## Test plan
- Reset: hold `rst_global` = 0 for 2 cycles with `start` = 1 → all outputs 0; no `edge_valid` in the cycle after release.
- Immediate convergence: `start` pulse, `relaxed` always 0 →
  - 64 consecutive `edge_valid` cycles, (0,0)..(7,7) in row-major order;
  - `iteration_done` 67 cycles after `start`;
  - then `finish` = 1, `converged` = 1, `iter_count` = 0.
- Multi-pass: `relaxed` = 1 on edge (2,5) in passes 0-2 only → 4 `iteration_done` pulses, `converged` = 1, `iter_count` = 3.
- Negative cycle: `relaxed` = 1 on edge (0,1) in every pass → 8 passes, `neg_cycle` = 1, `converged` = 0, `iter_count` = 7.
- Stall: `stall` = 1 for 5 cycles while edge (3,5) is current → addresses hold at (3,5), `edge_valid` = 0, `iteration_done` is delayed by exactly 5 cycles.
- Reset mid-sweep, and `start` while busy:
  - `rst_global` = 0 at edge (2,4) → all outputs 0 next cycle; a new `start` resumes at (0,0) with `iter_count` = 0.
  - `start` pulsed during SWEEP → no effect on the addresses.
